ser2par: RTL and testbench
==========================

# ser2par

Serial-to-parallel packer sitting directly upstream of `par2ser`: accepts a stream of `DWIDTH`-bit signed samples over a req/ack handshake and packs consecutive pairs into one `DDWIDTH`-bit word for the downstream stage. A two-sample staging buffer behind a one-word output register lets input continue while a packed word waits for `ack_out`. This sustains one sample per cycle when downstream acks continuously.

## Interface
- `DWIDTH`, 16, sample width in bits
- `DDWIDTH`, 32, packed word width; must equal 2*`DWIDTH` (elaboration error otherwise)

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `req_in`  output  1  block can accept a sample this cycle
- `ack_in`  input  1  upstream presents valid `data_in`
- `data_in`  input  [0:DWIDTH-1]  signed sample
- `req_out`  output  1  `data_out` holds a valid packed word
- `ack_out`  input  1  downstream takes `data_out`
- `data_out`  output  [0:DDWIDTH-1]  packed pair

## Operation
- Input transfer: `in_fire` = `req_in` & `ack_in` in the same cycle.
- Output transfer: `out_fire` = `req_out` & `ack_out` in the same cycle.
- `req_in` and `req_out` are decoded from state registers only; there is no combinational path from `ack_in`/`ack_out`.
- Staging state `scnt`:
  - EMPTY (0): no sample held.
  - HALF (1): `stage0` held.
  - PAIR (2): `stage0` and `stage1` held, no output slot available.
- Output register: `out_word` plus valid bit `ov`; `req_out` = `ov`.
- Packing: first-received sample goes to `data_out[0:DWIDTH-1]`, second to `data_out[DWIDTH:DDWIDTH-1]`; bits are copied, with no arithmetic or sign change.
- `req_in` = !`rst` & (`scnt` != PAIR).
- Per-cycle rules, in priority order:
  - EMPTY & `in_fire`: `stage0` <= `data_in`; go to HALF.
  - HALF & `in_fire` & (!`ov` | `out_fire`): `out_word` <= pack(`stage0`, `data_in`); `ov` <= 1; go to EMPTY.
  - HALF & `in_fire` & `ov` & !`out_fire`: `stage1` <= `data_in`; go to PAIR.
  - PAIR & (!`ov` | `out_fire`): `out_word` <= pack(`stage0`, `stage1`); `ov` <= 1; go to EMPTY.
  - Otherwise, `out_fire` clears `ov`.
- Simultaneous `in_fire` on the second sample and `out_fire`: the new word replaces the old one and `ov` stays 1, with no bubble.
- `out_word` is stable while `ov`=1 and !`out_fire`.

## Timing
- Reset values: `req_in`=0, `req_out`=0, `data_out`=0, `scnt`=EMPTY, `stage0`/`stage1`=0.
- `req_in` rises on the first cycle after `rst` falls.
- Latency: second sample's `in_fire` at cycle N gives `req_out`=1 and the valid word at N+1, when the output slot is free.
- Downstream stall: `ov` held, two more samples are accepted, and `req_in` drops the cycle after the second one, i.e. in PAIR.
- Leaving PAIR: `req_in` returns to 1 the cycle after `out_fire`, and `req_out` stays 1 carrying the staged word.
- Reset mid-operation: staged samples and the pending word are discarded, with no output for the partial pair.
- Throughput: one sample per cycle with `ack_in` and `ack_out` held high; one word every 2 cycles.

## Configuration
- `SER2PAR_SWAP_EN`:
  - Defined: the first-received sample is placed in `data_out[DWIDTH:DDWIDTH-1]` and the second in `data_out[0:DWIDTH-1]`.
  - Undefined (default): ordering as in Operation, matching the downstream `par2ser` emission order.
  - Handshake and timing are identical in both builds.

## Test plan
- Reset, then `ack_in`=1 with samples 0x1111, 0x2222 and `ack_out`=1 -> `req_out`=1 one cycle after the second transfer; `data_out`=0x11112222; `req_out` returns to 0 the next cycle.
- Streaming 0x0001..0x0008 at one sample per cycle with `ack_out` held 1 -> words 0x00010002, 0x00030004, 0x00050006, 0x00070008; `req_in` never drops.
- `ack_out`=0, feed 0xA, 0xB, 0xC, 0xD -> `data_out`=0x000A000B held; `req_in` drops after 0xD. Raise `ack_out` for 1 cycle -> `data_out`=0x000C000D and `req_in`=1 the next cycle.
- Assert `rst` for 1 cycle after a single sample 0x7FFF -> outputs return to reset values. Subsequent 0x8000, 0x0001 -> `data_out`=0x80000001, with no trace of 0x7FFF.
- With `SER2PAR_SWAP_EN` defined, feed 0x1234, 0xABCD -> `data_out`=0xABCD1234; cycle timing is identical to the default build.

Source files
------------

// File: rtl/ser2par_if.sv
// Handshake bundle between an upstream sample source, ser2par, and the downstream consumer.
// slave = packer side, master = environment driving samples and taking words.
interface ser2par_if #(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 32
);
    logic               req_in;
    logic               ack_in;
    logic [0:DWIDTH-1]  data_in;
    logic               req_out;
    logic               ack_out;
    logic [0:DDWIDTH-1] data_out;

    modport slave (
        output req_in,
        input  ack_in,
        input  data_in,
        output req_out,
        output data_out,
        input  ack_out
    );

    modport master (
        input  req_in,
        output ack_in,
        output data_in,
        input  req_out,
        input  data_out,
        output ack_out
    );
endinterface

// File: rtl/ser2par.sv
// Packs consecutive DWIDTH-bit samples into DDWIDTH-bit pairs; 1-cycle latency from the second sample.
// Backpressure: two-sample staging behind a one-word output register; req_in drops only when both are full.
// Optional build macro: SER2PAR_SWAP_EN (first sample placed in the low half of data_out).
module ser2par #(
    parameter int DWIDTH  = 16,
    parameter int DDWIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    ser2par_if.slave bus
);

    generate
        if (DDWIDTH != 2 * DWIDTH) begin : g_width_check
            $error("ser2par: DDWIDTH must equal 2*DWIDTH");
        end
    endgenerate

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] PAIR  = 2'd2;

    logic [1:0]         scnt;
    logic [0:DWIDTH-1]  stage0;
    logic [0:DWIDTH-1]  stage1;
    logic [0:DDWIDTH-1] out_word;
    logic               ov;

    logic in_fire;
    logic out_fire;
    logic slot_free;

    function automatic logic [0:DDWIDTH-1] pack(input logic [0:DWIDTH-1] first,
                                                 input logic [0:DWIDTH-1] second);
`ifdef SER2PAR_SWAP_EN
        return {second, first};
`else
        return {first, second};
`endif
    endfunction

    // Both requests come straight from registers so neither ack can loop back combinationally.
    assign bus.req_in   = !rst && (scnt != PAIR);
    assign bus.req_out  = ov;
    assign bus.data_out = out_word;

    assign in_fire   = bus.req_in && bus.ack_in;
    assign out_fire  = ov && bus.ack_out;
    assign slot_free = !ov || out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt     <= EMPTY;
            stage0   <= '0;
            stage1   <= '0;
            out_word <= '0;
            ov       <= 1'b0;
        end else begin
            // Taking the word frees the slot unless a new word is loaded below in the same cycle.
            if (out_fire) begin
                ov <= 1'b0;
            end
            case (scnt)
                EMPTY: begin
                    if (in_fire) begin
                        stage0 <= bus.data_in;
                        scnt   <= HALF;
                    end
                end
                HALF: begin
                    if (in_fire) begin
                        if (slot_free) begin
                            out_word <= pack(stage0, bus.data_in);
                            ov       <= 1'b1;
                            scnt     <= EMPTY;
                        end else begin
                            stage1 <= bus.data_in;
                            scnt   <= PAIR;
                        end
                    end
                end
                PAIR: begin
                    if (slot_free) begin
                        out_word <= pack(stage0, stage1);
                        ov       <= 1'b1;
                        scnt     <= EMPTY;
                    end
                end
                default: begin
                    scnt <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser2par.sv
// Directed bench for ser2par: expected words queued as pairs are sent, compared when the DUT delivers them.
module tb_ser2par;

    localparam int DW  = 16;
    localparam int DDW = 32;

    logic clk = 1'b0;
    logic rst;

    ser2par_if #(.DWIDTH(DW), .DDWIDTH(DDW)) bus ();

    ser2par #(.DWIDTH(DW), .DDWIDTH(DDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_words = 0;

    logic [DDW-1:0] exp_q[$];
    logic [DW-1:0]  first_s;
    bit             have_first;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DDW-1:0] model_pack(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SER2PAR_SWAP_EN
        return {b, a};
`else
        return {a, b};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample and waits (bounded) until the DUT accepts it; updates the pair model.
    task automatic send(input logic [DW-1:0] v, output int tries);
        bit fired;
        fired = 1'b0;
        tries = 0;
        bus.data_in = v;
        bus.ack_in  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            fired = bus.req_in;
            tries++;
            @(posedge clk);
            #1;
            if (fired) break;
        end
        bus.ack_in = 1'b0;
        if (!fired) begin
            check("send_timeout", 64'd0, 64'd1);
        end else if (have_first) begin
            exp_q.push_back(model_pack(first_s, v));
            have_first = 1'b0;
        end else begin
            first_s    = v;
            have_first = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        logic [DDW-1:0] e;
        if (bus.req_out && bus.ack_out) begin
            e = 'x;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("out_word", {32'd0, bus.data_out}, {32'd0, e});
            n_words++;
        end
    end

    initial begin
        int t;
        int stalls;
        have_first  = 1'b0;
        first_s     = '0;
        rst         = 1'b1;
        bus.ack_in  = 1'b0;
        bus.ack_out = 1'b0;
        bus.data_in = '0;
        tick();
        tick();
        #1;
        check("rst_req_in", 64'(bus.req_in), 64'd0);
        check("rst_req_out", 64'(bus.req_out), 64'd0);
        check("rst_data_out", 64'(bus.data_out), 64'd0);

        // basic pair
        rst = 1'b0;
        #1;
        check("req_in_after_rst", 64'(bus.req_in), 64'd1);
        bus.ack_out = 1'b1;
        send(16'h1111, t);
        send(16'h2222, t);
        #1;
        check("pair_req_out", 64'(bus.req_out), 64'd1);
        check("pair_data_out", 64'(bus.data_out), 64'h11112222);
        tick();
        #1;
        check("pair_req_out_drop", 64'(bus.req_out), 64'd0);

        // streaming at full rate
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), t);
            stalls += t - 1;
        end
        check("stream_no_stall", 64'(stalls), 64'd0);
        tick();
        tick();
        #1;
        check("stream_drained", 64'(bus.req_out), 64'd0);

        // downstream stall fills staging
        bus.ack_out = 1'b0;
        send(16'h000A, t);
        send(16'h000B, t);
        send(16'h000C, t);
        send(16'h000D, t);
        #1;
        check("stall_req_in", 64'(bus.req_in), 64'd0);
        check("stall_req_out", 64'(bus.req_out), 64'd1);
        check("stall_data", 64'(bus.data_out), 64'h000A000B);
        tick();
        #1;
        check("stall_hold_data", 64'(bus.data_out), 64'h000A000B);
        check("stall_hold_req_in", 64'(bus.req_in), 64'd0);
        bus.ack_out = 1'b1;
        tick();
        bus.ack_out = 1'b0;
        #1;
        check("unstall_req_in", 64'(bus.req_in), 64'd1);
        check("unstall_req_out", 64'(bus.req_out), 64'd1);
        check("unstall_data", 64'(bus.data_out), 64'h000C000D);
        bus.ack_out = 1'b1;
        tick();
        #1;
        check("unstall_drained", 64'(bus.req_out), 64'd0);

        // reset discards a half pair
        send(16'h7FFF, t);
        rst = 1'b1;
        #1;
        check("midrst_req_in", 64'(bus.req_in), 64'd0);
        tick();
        rst        = 1'b0;
        have_first = 1'b0;
        #1;
        check("midrst_req_out", 64'(bus.req_out), 64'd0);
        check("midrst_data_out", 64'(bus.data_out), 64'd0);
        send(16'h8000, t);
        send(16'h0001, t);
        #1;
        check("postrst_req_out", 64'(bus.req_out), 64'd1);
        tick();

        // ordering pair (swapped halves when built with the swap macro)
        send(16'h1234, t);
        send(16'hABCD, t);
        #1;
        check("order_req_out", 64'(bus.req_out), 64'd1);
        tick();
        #1;
        check("order_req_out_drop", 64'(bus.req_out), 64'd0);

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("words_seen", 64'(n_words), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
